tagged_regfile_mp: RTL

- Parametrised architectural register file with per-register rename status (busy bit plus ROB tag) for the Tomasulo back end.
- Replaces the single-commit, tag-zero-means-free register file.
- Serves NUM_RD read ports to the decoder and reservation stations, accepts NUM_CMT ROB commits per cycle plus one rename per cycle, and clears all rename state on flush.

---
 rtl/tagged_regfile_mp_pkg.sv | 30 +++
 rtl/tagged_regfile_mp_rf_read_port.sv | 67 ++++++
 rtl/tagged_regfile_mp.sv | 104 ++++++++++
 3 files changed

// File: rtl/tagged_regfile_mp_pkg.sv
// ============================================================================
// Module  : tagged_regfile_mp_pkg
// Brief   : Shared types and helpers for the tagged multi-port register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tagged_regfile_mp_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_TAG_W = 5;
    localparam int RF_NREGS = 32;

    typedef logic [4:0]          rv32i_reg;
    typedef logic [RF_XLEN-1:0]  rv32i_word;
    typedef logic [RF_TAG_W-1:0] tag_t;

    typedef struct packed {
        rv32i_word val;
        logic      busy;
        tag_t      tag;
    } rf_rd_port_t;

    function automatic logic is_x0(input rv32i_reg r);
        return (r == 5'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tagged_regfile_mp_rf_read_port.sv
// ============================================================================
// Module  : rf_read_port
// Brief   : One read port: state lookup, x0 masking, optional commit bypass
//           (enabled by REGFILE_CMT_BYPASS_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_read_port
    import tagged_regfile_mp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
`ifdef REGFILE_CMT_BYPASS_EN
    ,
    parameter int NUM_CMT = 2
`endif
) (
    input  logic [4:0]                   idx,
    input  logic [31:0][XLEN-1:0]        regs,
    input  logic [31:0]                  busy,
    input  logic [31:0][TAG_W-1:0]       tags,
`ifdef REGFILE_CMT_BYPASS_EN
    input  logic [NUM_CMT-1:0]           cmt_valid,
    input  logic [NUM_CMT*5-1:0]         cmt_rd,
    input  logic [NUM_CMT*TAG_W-1:0]     cmt_tag,
    input  logic [NUM_CMT*XLEN-1:0]      cmt_val,
`endif
    output logic [XLEN-1:0]              rd_val,
    output logic                         rd_busy,
    output logic [TAG_W-1:0]             rd_tag
);

`ifdef REGFILE_CMT_BYPASS_EN
    logic             w_hit;
    logic [TAG_W-1:0] w_hit_tag;
`endif

    always_comb begin
        rd_val  = regs[idx];
        rd_busy = busy[idx];
        rd_tag  = tags[idx];
`ifdef REGFILE_CMT_BYPASS_EN
        w_hit     = 1'b0;
        w_hit_tag = '0;
        // Ascending scan so the highest-index matching commit wins the value.
        for (int c = 0; c < NUM_CMT; c++) begin
            if (cmt_valid[c] && (cmt_rd[c*5 +: 5] == idx)) begin
                w_hit     = 1'b1;
                rd_val    = cmt_val[c*XLEN +: XLEN];
                w_hit_tag = cmt_tag[c*TAG_W +: TAG_W];
            end
        end
        if (w_hit && rd_busy && (w_hit_tag == rd_tag)) begin
            rd_busy = 1'b0;
        end
`endif
        if (is_x0(idx)) begin
            rd_val  = '0;
            rd_busy = 1'b0;
            rd_tag  = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tagged_regfile_mp.sv
// ============================================================================
// Module  : tagged_regfile_mp
// Brief   : Architectural register file with busy bit and ROB tag per register,
//           NUM_RD read ports, NUM_CMT commits, one rename, flush.
//           Optional same-cycle commit bypass: REGFILE_CMT_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tagged_regfile_mp
    import tagged_regfile_mp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5,
    parameter int NUM_RD  = 6,
    parameter int NUM_CMT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     ren_valid_i,
    input  logic [4:0]               ren_rd_i,
    input  logic [TAG_W-1:0]         ren_tag_i,
    input  logic [NUM_CMT-1:0]       cmt_valid_i,
    input  logic [NUM_CMT*5-1:0]     cmt_rd_i,
    input  logic [NUM_CMT*TAG_W-1:0] cmt_tag_i,
    input  logic [NUM_CMT*XLEN-1:0]  cmt_val_i,
    input  logic [NUM_RD*5-1:0]      rd_idx_i,
    output logic [NUM_RD*XLEN-1:0]   rd_val_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic [NUM_RD*TAG_W-1:0]  rd_tag_o
);

    logic [31:1][XLEN-1:0]  r_regs;
    logic [31:1]            r_busy;
    logic [31:1][TAG_W-1:0] r_tag;

    logic [31:0][XLEN-1:0]  w_regs_all;
    logic [31:0]            w_busy_all;
    logic [31:0][TAG_W-1:0] w_tag_all;

    always_comb begin
        w_regs_all        = '0;
        w_busy_all        = '0;
        w_tag_all         = '0;
        w_regs_all[31:1]  = r_regs;
        w_busy_all[31:1]  = r_busy;
        w_tag_all[31:1]   = r_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '0;
            r_busy <= '0;
            r_tag  <= '0;
        end else begin
            // Later ports override earlier ones on the value; each busy
            // clear compares against the pre-edge tag independently.
            for (int c = 0; c < NUM_CMT; c++) begin
                if (cmt_valid_i[c] && !is_x0(cmt_rd_i[c*5 +: 5])) begin
                    r_regs[cmt_rd_i[c*5 +: 5]] <= cmt_val_i[c*XLEN +: XLEN];
                    if (r_busy[cmt_rd_i[c*5 +: 5]] &&
                        (r_tag[cmt_rd_i[c*5 +: 5]] == cmt_tag_i[c*TAG_W +: TAG_W])) begin
                        r_busy[cmt_rd_i[c*5 +: 5]] <= 1'b0;
                    end
                end
            end
            if (flush) begin
                r_busy <= '0;
            end else if (ren_valid_i && !is_x0(ren_rd_i)) begin
                r_busy[ren_rd_i] <= 1'b1;
                r_tag[ren_rd_i]  <= ren_tag_i;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
        rf_read_port #(
            .XLEN    (XLEN),
            .TAG_W   (TAG_W)
`ifdef REGFILE_CMT_BYPASS_EN
            ,
            .NUM_CMT (NUM_CMT)
`endif
        ) u_rd_port (
            .idx       (rd_idx_i[p*5 +: 5]),
            .regs      (w_regs_all),
            .busy      (w_busy_all),
            .tags      (w_tag_all),
`ifdef REGFILE_CMT_BYPASS_EN
            .cmt_valid (cmt_valid_i),
            .cmt_rd    (cmt_rd_i),
            .cmt_tag   (cmt_tag_i),
            .cmt_val   (cmt_val_i),
`endif
            .rd_val    (rd_val_o[p*XLEN +: XLEN]),
            .rd_busy   (rd_busy_o[p]),
            .rd_tag    (rd_tag_o[p*TAG_W +: TAG_W])
        );
    end

endmodule

`default_nettype wire
